// File: rtl/noc_pkg.sv
// Shared NoC router definitions used by the output buffers and the routing stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

    // Output-buffer geometry; OB_DEPTH must stay equal to 2**OB_WIDTH so the
    // pointers can wrap by plain binary overflow.
    localparam int OB_WIDTH  = 3;
    localparam int OB_DEPTH  = 1 << OB_WIDTH;
    localparam int FLIT_SIZE = 40;

    // One-hot output direction, shared with the routing stage's port select.
    typedef enum logic [3:0] {
        DIR_E = 4'b0001,
        DIR_W = 4'b0010,
        DIR_S = 4'b0100,
        DIR_L = 4'b1000
    } dir_e;

    // Occupancy width needed to represent 0..depth inclusive.
    function automatic int occ_width(input int ptr_width);
        return ptr_width + 1;
    endfunction

endpackage

// File: rtl/ob_tx_mem.sv
// Flit storage for the output buffer: one synchronous write port, one async read port.
// Latency: write visible on rd_data the cycle after the write edge; read is combinational.
// Backpressure: none here; the controller in ob_tx decides when writes happen.
//
// Ports: clk, wr_en/wr_addr/wr_data (write port), rd_addr/rd_data (read port).
// The array is deliberately not reset; validity is tracked by the controller.
module ob_tx_mem #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_addr,
    input  logic [DATASIZE-1:0] wr_data,
    input  logic [WIDTH-1:0]    rd_addr,
    output logic [DATASIZE-1:0] rd_data
);

    logic [DATASIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ob_tx.sv
// Per-direction router output buffer: FIFO of flits toward the neighbour router.
// Latency: one cycle from accepted write to data_out/valid_out (no bypass).
// Backpressure: ready_out drops when full; head flit holds while ready_in is low.
//
// Ports: ob_clk, rst (sync, active-high); data_in/valid_in/ready_out from the
// crossbar; data_out/valid_out/ready_in toward the neighbour; pressure_out is the
// registered occupancy used for adaptive routing. Instantiated once per E/W/S/L.
module ob_tx
    import noc_pkg::*;
#(
    parameter int DEPTH    = OB_DEPTH,
    parameter int WIDTH    = OB_WIDTH,
    parameter int DATASIZE = FLIT_SIZE
) (
    input  logic                ob_clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic [WIDTH:0]      pressure_out
);

    localparam logic [WIDTH:0]   COUNT_FULL = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0]   COUNT_ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] PTR_ONE    = WIDTH'(1);

    logic [WIDTH-1:0]    wr_ptr;
    logic [WIDTH-1:0]    rd_ptr;
    logic [WIDTH:0]      count;
    logic                wr_en;
    logic                rd_en;
    logic [DATASIZE-1:0] head_data;

    // Handshake outputs depend only on the registered count, so there is no
    // combinational path from valid_in/ready_in to ready_out/valid_out.
    assign ready_out    = (count != COUNT_FULL);
    assign valid_out    = (count != '0);
    assign pressure_out = count;

    // Gating with ready_out/valid_out makes a write into a full buffer and a
    // read from an empty one no-ops, even if the other side transfers.
    assign wr_en = valid_in && ready_out;
    assign rd_en = valid_out && ready_in;

    ob_tx_mem #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .DATASIZE (DATASIZE)
    ) u_mem (
        .clk     (ob_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (head_data)
    );

    // Stale array contents are masked so an empty buffer always shows zero.
    assign data_out = valid_out ? head_data : '0;

    // Pointers wrap DEPTH-1 -> 0 by WIDTH-bit overflow (DEPTH == 2**WIDTH).
    always_ff @(posedge ob_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ob_tx.sv
module tb_ob_tx;

    localparam int DS = 40;

    logic          ob_clk = 1'b0;
    logic          rst;
    logic [DS-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic [DS-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic [3:0]    pressure_out;

    int checks = 0;
    int errors = 0;

    logic [DS-1:0] exp_q [$];

    ob_tx dut (
        .ob_clk       (ob_clk),
        .rst          (rst),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .pressure_out (pressure_out)
    );

    always #5 ob_clk = ~ob_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge ob_clk);
        #1;
    endtask

    // Scoreboard monitor: a transfer happens at the next rising edge whenever
    // valid_out && ready_in are both high mid-cycle.
    always @(negedge ob_clk) begin
        if (!rst && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit: got %0h expected none", data_out);
            end else begin
                chk("flit_order", data_out, exp_q.pop_front());
            end
        end
    end

    // Present one flit for one cycle; push to scoreboard only if it should be accepted.
    task automatic put(input logic [DS-1:0] d, input bit expect_accept);
        data_in  = d;
        valid_in = 1'b1;
        if (expect_accept) exp_q.push_back(d);
        cyc();
        valid_in = 1'b0;
    endtask

    task automatic drain(input int n);
        ready_in = 1'b1;
        repeat (n) cyc();
        ready_in = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        data_in  = '0;
        valid_in = 1'b0;
        ready_in = 1'b0;

        // Reset then idle
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_ready_out", ready_out, 1);
        chk("rst_pressure", pressure_out, 0);
        chk("rst_data_out", data_out, 0);

        // Single flit
        put(40'hA5_0000_0001, 1);
        chk("single_valid", valid_out, 1);
        chk("single_data", data_out, 40'hA5_0000_0001);
        chk("single_pressure", pressure_out, 1);
        cyc();
        chk("single_hold_data", data_out, 40'hA5_0000_0001);
        drain(1);
        chk("single_empty_valid", valid_out, 0);
        chk("single_empty_pressure", pressure_out, 0);
        chk("single_empty_data", data_out, 0);

        // Fill to full, 9th write ignored, drain in order
        for (int i = 1; i <= 8; i++) put(DS'(i), 1);
        chk("fill_pressure", pressure_out, 8);
        chk("fill_ready_out", ready_out, 0);
        put(40'd9, 0);
        chk("fill_9th_pressure", pressure_out, 8);
        chk("fill_head_hold", data_out, 1);
        drain(8);
        chk("fill_drained_pressure", pressure_out, 0);
        chk("fill_drained_ready", ready_out, 1);

        // Full with simultaneous read: incoming flit must be dropped
        for (int i = 1; i <= 8; i++) put(40'h100 + DS'(i), 1);
        data_in  = 40'hDE_AD00_BEEF;
        valid_in = 1'b1;
        ready_in = 1'b1;
        cyc();
        valid_in = 1'b0;
        ready_in = 1'b0;
        chk("full_rw_pressure", pressure_out, 7);
        chk("full_rw_head", data_out, 40'h102);
        drain(7);
        chk("full_rw_drained", pressure_out, 0);
        chk("full_rw_valid", valid_out, 0);

        // Streaming across pointer wrap
        ready_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            put(40'h200 + DS'(i), 1);
            valid_in = 1'b1;
            chk("stream_pressure", pressure_out, 1);
        end
        valid_in = 1'b0;
        cyc();
        ready_in = 1'b0;
        chk("stream_end_pressure", pressure_out, 0);

        // Reset mid-operation discards buffered flits
        for (int i = 0; i < 5; i++) put(40'h300 + DS'(i), 1);
        chk("mid_pressure", pressure_out, 5);
        rst = 1'b1;
        valid_in = 1'b1;
        data_in  = 40'h3FF;
        ready_in = 1'b1;
        exp_q.delete();
        cyc();
        rst      = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        chk("mid_rst_pressure", pressure_out, 0);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_ready", ready_out, 1);
        chk("mid_rst_data", data_out, 0);
        put(40'h3AA, 1);
        chk("post_rst_head", data_out, 40'h3AA);
        drain(1);
        chk("post_rst_empty", pressure_out, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ob_tx.md
OB_TX -- requirements
Module: ob_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, buffer depth in flits; DEPTH SHALL equal 2**WIDTH.
REQ-002 SHALL have parameter WIDTH, default 3, pointer width; occupancy/pressure width is WIDTH+1.
REQ-003 SHALL have parameter DATASIZE, default 40, flit width.
REQ-004 SHALL have port ob_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port data_in  input  DATASIZE  flit from crossbar for this output direction.
REQ-007 SHALL have port valid_in  input  1  data_in carries a flit this cycle.
REQ-008 SHALL have port ready_out  output  1  buffer can accept a flit (not full).
REQ-009 SHALL have port data_out  output  DATASIZE  head flit toward neighbour router input.
REQ-010 SHALL have port valid_out  output  1  data_out holds a valid flit.
REQ-011 SHALL have port ready_in  input  1  neighbour routing stage accepts flit (its rc_ready).
REQ-012 SHALL have port pressure_out  output  WIDTH+1  occupancy count, feeds neighbour/local *_pressure_in for adaptive routing.

Function
REQ-013 SHALL store flits in a DEPTH-entry circular buffer with write pointer wr_ptr, read pointer rd_ptr (WIDTH bits each) and count (WIDTH+1 bits, range 0..DEPTH).
REQ-014 SHALL perform a write when valid_in && ready_out: mem[wr_ptr] <= data_in, wr_ptr increments.
REQ-015 SHALL perform a read when valid_out && ready_in: rd_ptr increments.
REQ-016 SHALL wrap both pointers from DEPTH-1 to 0 by natural WIDTH-bit overflow.
REQ-017 SHALL update count: +1 on write only, -1 on read only, unchanged on simultaneous write and read or on neither.
REQ-018 SHALL drive ready_out = (count != DEPTH), valid_out = (count != 0), pressure_out = count, all derived from registered count only (no combinational path from valid_in/ready_in).
REQ-019 SHALL present first-word-fall-through data: data_out = mem[rd_ptr] when valid_out=1, all-zero when valid_out=0.
REQ-020 SHALL have latency one cycle: flit written at edge N appears on data_out/valid_out after edge N (empty-buffer case); no same-cycle bypass.
REQ-021 Full boundary: when count=DEPTH, ready_out=0 and valid_in SHALL be ignored even if a read occurs that cycle.
REQ-022 Empty boundary: when count=0, ready_in SHALL be ignored and rd_ptr/count unchanged.
REQ-023 SHALL hold data_out and valid_out stable while valid_out=1 and ready_in=0.
REQ-024 SHALL preserve flit order strictly (FIFO); no flit dropped or duplicated.

Reset
REQ-025 SHALL on rst=1 at a clock edge clear wr_ptr, rd_ptr and count to 0, regardless of concurrent valid_in/ready_in.
REQ-026 SHALL present after reset: valid_out=0, data_out=0, ready_out=1, pressure_out=0.
REQ-027 SHALL discard all buffered flits on reset mid-operation; storage array itself needs no reset.

Structure
REQ-028 SHALL take DEPTH/WIDTH/DATASIZE defaults and the 4-bit direction encoding from shared package noc_pkg, common with the routing stage.
REQ-029 SHALL place the storage array in one sub-module ob_tx_mem (write port, asynchronous read port); pointer/count control stays in ob_tx.
REQ-030 SHALL be instantiated once per router output direction (E, W, S, L).

Verification
REQ-031 Reset then idle: rst high 2 cycles -> valid_out=0, ready_out=1, pressure_out=0, data_out=0.
REQ-032 Single flit: write 40'hA5_0000_0001 with ready_in=0 -> next cycle valid_out=1, data_out=40'hA5_0000_0001, pressure_out=1; raise ready_in one cycle -> valid_out=0, pressure_out=0.
REQ-033 Fill: 8 writes, ready_in=0 -> pressure_out=8, ready_out=0; 9th valid_in ignored; drain returns flits 1..8 in order.
REQ-034 Full with simultaneous read: count=8, valid_in=1, ready_in=1 -> count=7, incoming flit not stored.
REQ-035 Wrap-around: 20 flits streamed with valid_in=1, ready_in=1 continuously after first -> pressure_out holds 1, all 20 delivered in order across pointer wrap.
REQ-036 Reset mid-operation: 5 flits buffered, rst one cycle -> pressure_out=0, valid_out=0; next written flit is first delivered.
